pw_digit_buf: RTL and testbench
===============================

# pw_digit_buf

Parametrised password-entry buffer for the door-lock datapath. It replaces the fixed 128-bit shift-only keypad register with a configurable digit store. It adds digit insertion, backspace, an entry counter with full/overflow detection, a stored-password bank with length check, registered compare, and an idle-timeout auto-clear. It sits between the keypad decoder and the lock control FSM.

## Interface

**Parameters**
- `DIGIT_W`, 4: bits per digit.
- `MAX_DIGITS`, 32: buffer depth in digits.
- `MIN_DIGITS`, 4: minimum length accepted by `store`.
- `TIMEOUT_CYC`, 1000000: idle cycles before auto-clear. 0 disables the timeout.

**Ports**
- `clk` in 1: clock. All logic is on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous clear of the entry buffer.
- `push` in 1: append `digit_in`.
- `pop` in 1: backspace, removing the last digit.
- `digit_in` in `DIGIT_W`: digit to append.
- `store` in 1: commit the entry as the stored password.
- `check` in 1: compare the entry against the stored password.
- `entry` out `DIGIT_W*MAX_DIGITS`: entry buffer. The newest digit is in the LSBs.
- `count` out `$clog2(MAX_DIGITS+1)`: number of digits entered.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == MAX_DIGITS`.
- `ovf` out 1: sticky flag, set by a push while full.
- `stored_set` out 1: a valid password has been stored.
- `store_ok` out 1: one-cycle pulse, commit accepted.
- `store_err` out 1: one-cycle pulse, commit rejected because the length is out of range.
- `match_vld` out 1: one-cycle pulse, compare result is valid.
- `match` out 1: compare result, qualified by `match_vld`.
- `timeout` out 1: one-cycle pulse, entry auto-cleared.

## Operation

**Blank digit.** `BLANK` is all ones. Unused digit slots always hold `BLANK`.

**Command priority, one action per cycle:** `clr` > `store` > `check` > `pop`/`push`. Lower-priority inputs in the same cycle are ignored.

**Entry commands**
- `push` with `!full`:
  - `entry <= {entry[DIGIT_W*(MAX_DIGITS-1)-1:0], digit_in}`
  - `count <= count + 1`
- `push` with `full`: entry and count are unchanged; `ovf <= 1`.
- `pop` with `!empty`:
  - `entry <= {BLANK, entry[DIGIT_W*MAX_DIGITS-1:DIGIT_W]}`
  - `count <= count - 1`
- `pop` with `empty`: no effect and no error.
- `push` and `pop` in the same cycle: both are ignored. The idle timer is still restarted.

**Clear.** `clr` sets `entry` to all `BLANK`, `count` to 0 and `ovf` to 0. The stored bank is untouched.

**Store**
- Accepted when `MIN_DIGITS <= count <= MAX_DIGITS` and `!ovf`. Then `stored <= entry`, `stored_cnt <= count`, `stored_set <= 1`, and `store_ok` pulses.
- Otherwise `store_err` pulses and the stored bank is unchanged.
- The entry is cleared in both cases.

**Check**
- `match <= stored_set && !ovf && (count == stored_cnt) && (entry == stored)`.
- `match_vld` pulses.
- The entry is cleared.
- `match` holds its value until the next `check`.

**Idle timer**
- Counts up while `count > 0` and there is no command.
- Restarts to 0 on any command or when the entry is empty.
- On reaching `TIMEOUT_CYC` (when `TIMEOUT_CYC > 0`): the entry is cleared as if by `clr` and `timeout` pulses.
- An explicit command arriving in the same cycle as expiry wins, and `timeout` does not fire.

## Timing

- All outputs are registered.
- Entry, count and flags update one cycle after the command edge.
- `store_ok`, `store_err`, `match_vld` and `timeout` are asserted for exactly one cycle, in the cycle after the command edge (or after the expiry edge for `timeout`).
- **Reset values:**
  - `entry` and `stored` are all `BLANK`.
  - `count`, `stored_cnt` and the idle counter are 0.
  - `empty` is 1.
  - `full`, `ovf`, `stored_set`, `match`, `match_vld`, `store_ok`, `store_err` and `timeout` are 0.
- Reset asserted mid-entry or mid-compare aborts the operation immediately. No pulse is emitted after release.
- `store` or `check` in back-to-back cycles: each is evaluated against the entry as already cleared by the previous cycle.

## Structure

- Package `pw_pkg` holds:
  - the `BLANK` digit constant function of `DIGIT_W`;
  - `CNT_W = $clog2(MAX_DIGITS+1)`;
  - the command-select enum: `CMD_NONE`, `CMD_CLR`, `CMD_STORE`, `CMD_CHECK`, `CMD_POP`, `CMD_PUSH`, `CMD_TIMEOUT`.
- One sub-module, `pw_idle_timer`:
  - parameter `TIMEOUT_CYC`;
  - inputs `restart` and `run`;
  - output `expire`, a one-cycle pulse;
  - a 0-width-safe disable path when `TIMEOUT_CYC == 0`.

## Test plan

1. Reset, then push 1,2,3,4 → `count`=4, `entry[15:0]`=16'h1234, upper bits all F, `empty`=0.
2. Push 1,2,3,4, pop → `count`=3, `entry[11:0]`=12'h123, `entry[15:12]`=F. Then pop 3 more times, plus one extra pop → `count`=0, `empty`=1, `ovf`=0.
3. Push 32 digits (value 5), then push 6 → `full`=1, `ovf`=1, `count`=32, `entry[3:0]`=5. Then `store` → `store_err` pulse, `stored_set`=0, `count`=0.
4. Push 9,8,7,6, `store` → `store_ok`, `stored_set`=1. Push 9,8,7,6, `check` → `match_vld`=1 and `match`=1 one cycle later. Push 9,8,7, `check` → `match`=0 (length mismatch).
5. `TIMEOUT_CYC`=10: push 3, idle 10 cycles → `timeout` pulse, `count`=0. Repeat with a push at idle cycle 10 → no `timeout`.
6. `push`+`pop` same cycle at `count`=2 → `count` stays 2. `clr`+`push` same cycle → `count`=0. Reset asserted during `check` cycle → `match_vld` stays 0.

Source files
------------

// File: rtl/pw_pkg.sv
// pw_pkg: shared types and helpers for the password digit buffer.
//   pw_cmd_e    - per-cycle command select, highest-priority action wins
//   cnt_w()     - width of a digit counter able to hold 0..max_digits
//   blank_digit - the all-ones "no digit" value for a given digit width (<= 64)
package pw_pkg;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_CLR,
        CMD_STORE,
        CMD_CHECK,
        CMD_POP,
        CMD_PUSH,
        CMD_TIMEOUT
    } pw_cmd_e;

    function automatic int unsigned cnt_w(input int unsigned max_digits);
        return $clog2(max_digits + 1);
    endfunction

    function automatic logic [63:0] blank_digit(input int unsigned digit_w);
        return {64{1'b1}} >> (64 - digit_w);
    endfunction

endpackage

// File: rtl/pw_idle_timer.sv
// pw_idle_timer: idle watchdog for the entry buffer.
//   clk, rstn : clock, asynchronous active-low reset
//   restart   : any user command this cycle; zeroes the counter
//   run       : entry is non-empty; counting only happens while set
//   expire    : single-cycle pulse on the TIMEOUT_CYC-th consecutive idle cycle
// TIMEOUT_CYC == 0 removes the counter entirely and ties expire low.
module pw_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

            logic [W-1:0] idle_q;
            logic [W-1:0] idle_d;
            logic         hit;

            // Counter holds the number of idle cycles already elapsed, so the
            // cycle it reads TIMEOUT_CYC-1 is the TIMEOUT_CYC-th idle cycle.
            always_comb begin
                hit = run && !restart && (idle_q == W'(TIMEOUT_CYC - 1));
                if (restart || !run || hit) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    idle_q <= '0;
                end else begin
                    idle_q <= idle_d;
                end
            end

            assign expire = hit;
        end
    endgenerate

endmodule

// File: rtl/pw_digit_buf.sv
// pw_digit_buf: keypad password entry buffer with stored-password bank.
//   clk, rstn        : clock, asynchronous active-low reset
//   clr              : clear entry (entry, count, ovf)
//   push / digit_in  : append digit (newest at LSBs)
//   pop              : backspace
//   store            : commit entry as stored password (length checked)
//   check            : compare entry with stored password
//   entry, count     : entry buffer and digit count
//   empty, full, ovf : count flags; ovf is sticky until the entry is cleared
//   stored_set       : a password has been accepted
//   store_ok/err     : single-cycle commit result pulses
//   match_vld, match : single-cycle compare strobe, match held until next check
//   timeout          : single-cycle pulse when the idle timer cleared the entry
// Priority: clr > store > check > pop/push; push+pop together is a no-op.
module pw_digit_buf
    import pw_pkg::*;
#(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned MAX_DIGITS  = 32,
    parameter int unsigned MIN_DIGITS  = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clr,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              store,
    input  logic                              check,
    output logic [DIGIT_W*MAX_DIGITS-1:0]     entry,
    output logic [cnt_w(MAX_DIGITS)-1:0]      count,
    output logic                              empty,
    output logic                              full,
    output logic                              ovf,
    output logic                              stored_set,
    output logic                              store_ok,
    output logic                              store_err,
    output logic                              match_vld,
    output logic                              match,
    output logic                              timeout
);

    localparam int unsigned         CNT_W   = cnt_w(MAX_DIGITS);
    localparam int unsigned         BUF_W   = DIGIT_W * MAX_DIGITS;
    localparam logic [DIGIT_W-1:0]  BLANK   = DIGIT_W'(blank_digit(DIGIT_W));
    localparam logic [CNT_W-1:0]    MIN_CNT = CNT_W'(MIN_DIGITS);
    localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_DIGITS);

    logic [BUF_W-1:0] entry_q,      entry_d;
    logic [BUF_W-1:0] stored_q,     stored_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic [CNT_W-1:0] stored_cnt_q, stored_cnt_d;
    logic             empty_q,      empty_d;
    logic             full_q,       full_d;
    logic             ovf_q,        ovf_d;
    logic             stored_set_q, stored_set_d;
    logic             store_ok_q,   store_ok_d;
    logic             store_err_q,  store_err_d;
    logic             match_vld_q,  match_vld_d;
    logic             match_q,      match_d;
    logic             timeout_q,    timeout_d;

    pw_cmd_e cmd;
    logic    restart;
    logic    expire;

    // Any user command (including the ignored push+pop pair) restarts the timer.
    assign restart = clr | store | check | push | pop;

    pw_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .run     (count_q != '0),
        .expire  (expire)
    );

    always_comb begin
        cmd = CMD_NONE;
        if (clr) begin
            cmd = CMD_CLR;
        end else if (store) begin
            cmd = CMD_STORE;
        end else if (check) begin
            cmd = CMD_CHECK;
        end else if (push && pop) begin
            cmd = CMD_NONE;
        end else if (pop) begin
            cmd = CMD_POP;
        end else if (push) begin
            cmd = CMD_PUSH;
        end else if (expire) begin
            cmd = CMD_TIMEOUT;
        end
    end

    always_comb begin
        entry_d      = entry_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        stored_d     = stored_q;
        stored_cnt_d = stored_cnt_q;
        stored_set_d = stored_set_q;
        match_d      = match_q;
        store_ok_d   = 1'b0;
        store_err_d  = 1'b0;
        match_vld_d  = 1'b0;
        timeout_d    = 1'b0;

        case (cmd)
            CMD_CLR: begin
                entry_d = '1;
                count_d = '0;
                ovf_d   = 1'b0;
            end
            CMD_STORE: begin
                if (count_q >= MIN_CNT && count_q <= MAX_CNT && !ovf_q) begin
                    stored_d     = entry_q;
                    stored_cnt_d = count_q;
                    stored_set_d = 1'b1;
                    store_ok_d   = 1'b1;
                end else begin
                    store_err_d  = 1'b1;
                end
                entry_d = '1;
                count_d = '0;
                ovf_d   = 1'b0;
            end
            CMD_CHECK: begin
                match_d     = stored_set_q && !ovf_q && (count_q == stored_cnt_q)
                              && (entry_q == stored_q);
                match_vld_d = 1'b1;
                entry_d     = '1;
                count_d     = '0;
                ovf_d       = 1'b0;
            end
            CMD_POP: begin
                if (count_q != '0) begin
                    entry_d = {BLANK, entry_q[BUF_W-1:DIGIT_W]};
                    count_d = count_q - 1'b1;
                end
            end
            CMD_PUSH: begin
                if (count_q == MAX_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    entry_d = {entry_q[BUF_W-DIGIT_W-1:0], digit_in};
                    count_d = count_q + 1'b1;
                end
            end
            CMD_TIMEOUT: begin
                entry_d   = '1;
                count_d   = '0;
                ovf_d     = 1'b0;
                timeout_d = 1'b1;
            end
            default: begin
            end
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == MAX_CNT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entry_q      <= '1;
            stored_q     <= '1;
            count_q      <= '0;
            stored_cnt_q <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            ovf_q        <= 1'b0;
            stored_set_q <= 1'b0;
            store_ok_q   <= 1'b0;
            store_err_q  <= 1'b0;
            match_vld_q  <= 1'b0;
            match_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            stored_q     <= stored_d;
            count_q      <= count_d;
            stored_cnt_q <= stored_cnt_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            ovf_q        <= ovf_d;
            stored_set_q <= stored_set_d;
            store_ok_q   <= store_ok_d;
            store_err_q  <= store_err_d;
            match_vld_q  <= match_vld_d;
            match_q      <= match_d;
            timeout_q    <= timeout_d;
        end
    end

    assign entry      = entry_q;
    assign count      = count_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign ovf        = ovf_q;
    assign stored_set = stored_set_q;
    assign store_ok   = store_ok_q;
    assign store_err  = store_err_q;
    assign match_vld  = match_vld_q;
    assign match      = match_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pw_digit_buf.sv
// Testbench for pw_digit_buf: directed scenarios followed by random traffic,
// every cycle checked against a queue-based reference model.
module tb_pw_digit_buf;

    localparam int unsigned DW  = 4;
    localparam int unsigned MAXD = 32;
    localparam int unsigned MIND = 4;
    localparam int unsigned TO  = 10;

    logic                clk;
    logic                rstn;
    logic                clr, push, pop, store, check;
    logic [DW-1:0]       digit_in;
    logic [DW*MAXD-1:0]  entry;
    logic [5:0]          count;
    logic                empty, full, ovf, stored_set;
    logic                store_ok, store_err, match_vld, match, timeout;

    pw_digit_buf #(
        .DIGIT_W     (DW),
        .MAX_DIGITS  (MAXD),
        .MIN_DIGITS  (MIND),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .push       (push),
        .pop        (pop),
        .digit_in   (digit_in),
        .store      (store),
        .check      (check),
        .entry      (entry),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .ovf        (ovf),
        .stored_set (stored_set),
        .store_ok   (store_ok),
        .store_err  (store_err),
        .match_vld  (match_vld),
        .match      (match),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: entered digits (oldest first), stored password, flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] sq[$];
    bit m_set, m_ovf, m_match;
    bit e_ok, e_err, e_vld, e_to;
    int idle;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] exp_entry();
        logic [127:0] v;
        v = '1;
        for (int i = 0; i < q.size(); i++) v[DW*i +: DW] = q[q.size()-1-i];
        return v;
    endfunction

    function automatic bit q_eq();
        if (q.size() != sq.size()) return 1'b0;
        for (int i = 0; i < q.size(); i++) if (q[i] != sq[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        sq.delete();
        m_set = 0; m_ovf = 0; m_match = 0;
        e_ok = 0; e_err = 0; e_vld = 0; e_to = 0;
        idle = 0;
    endtask

    task automatic check_all();
        chk("entry",      entry,      exp_entry());
        chk("count",      count,      128'(q.size()));
        chk("empty",      empty,      128'(q.size() == 0));
        chk("full",       full,       128'(q.size() == MAXD));
        chk("ovf",        ovf,        128'(m_ovf));
        chk("stored_set", stored_set, 128'(m_set));
        chk("store_ok",   store_ok,   128'(e_ok));
        chk("store_err",  store_err,  128'(e_err));
        chk("match_vld",  match_vld,  128'(e_vld));
        chk("match",      match,      128'(m_match));
        chk("timeout",    timeout,    128'(e_to));
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic step(input bit c, input bit s, input bit k, input bit pu, input bit po,
                        input logic [DW-1:0] d);
        clr = c; store = s; check = k; push = pu; pop = po; digit_in = d;
        e_ok = 0; e_err = 0; e_vld = 0; e_to = 0;
        if (c) begin
            model_clear(); idle = 0;
        end else if (s) begin
            if (q.size() >= MIND && q.size() <= MAXD && !m_ovf) begin
                sq = q; m_set = 1; e_ok = 1;
            end else begin
                e_err = 1;
            end
            model_clear(); idle = 0;
        end else if (k) begin
            m_match = m_set && !m_ovf && q_eq();
            e_vld = 1;
            model_clear(); idle = 0;
        end else if (pu || po) begin
            idle = 0;
            if (pu && !po) begin
                if (q.size() == MAXD) m_ovf = 1;
                else q.push_back(d);
            end else if (po && !pu) begin
                if (q.size() > 0) void'(q.pop_back());
            end
        end else if (q.size() == 0) begin
            idle = 0;
        end else begin
            idle++;
            if (idle == TO) begin
                model_clear(); e_to = 1; idle = 0;
            end
        end
        @(posedge clk);
        #1;
        clr = 0; store = 0; check = 0; push = 0; pop = 0;
        check_all();
    endtask

    task automatic do_push(input logic [DW-1:0] d); step(0, 0, 0, 1, 0, d); endtask
    task automatic do_pop();  step(0, 0, 0, 0, 1, '0); endtask
    task automatic do_idle(); step(0, 0, 0, 0, 0, '0); endtask
    task automatic do_clr();  step(1, 0, 0, 0, 0, '0); endtask
    task automatic do_store(); step(0, 1, 0, 0, 0, '0); endtask
    task automatic do_check(); step(0, 0, 1, 0, 0, '0); endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pw[$];
        int n;
        int r;
        clr = 0; push = 0; pop = 0; store = 0; check = 0; digit_in = '0;
        rstn = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        check_all();

        // 1: basic push
        do_push(4'h1); do_push(4'h2); do_push(4'h3); do_push(4'h4);
        chk("t1_lo", entry[15:0], 128'h1234);
        chk("t1_hi", entry[127:16], {16'h0, {112{1'b1}}});

        // 2: backspace down to empty and beyond
        do_clr();
        do_push(4'h1); do_push(4'h2); do_push(4'h3); do_push(4'h4);
        do_pop();
        chk("t2_lo", entry[15:0], 128'hF123);
        repeat (4) do_pop();
        chk("t2_empty", empty, 128'h1);

        // 3: overflow then rejected store
        for (int i = 0; i < 32; i++) do_push(4'h5);
        do_push(4'h6);
        chk("t3_ovf", ovf, 128'h1);
        chk("t3_lsd", entry[3:0], 128'h5);
        do_store();
        chk("t3_err", store_err, 128'h1);

        // 4: store, matching check, short check
        do_push(4'h9); do_push(4'h8); do_push(4'h7); do_push(4'h6);
        do_store();
        chk("t4_ok", store_ok, 128'h1);
        do_push(4'h9); do_push(4'h8); do_push(4'h7); do_push(4'h6);
        do_check();
        chk("t4_match", {match_vld, match}, 128'h3);
        do_push(4'h9); do_push(4'h8); do_push(4'h7);
        do_check();
        chk("t4_short", {match_vld, match}, 128'h2);
        do_check();
        do_store();

        // 5: idle timeout, and a command on the expiry cycle beats it
        do_push(4'h3);
        repeat (10) do_idle();
        chk("t5_to", timeout, 128'h1);
        do_push(4'h3);
        repeat (9) do_idle();
        do_push(4'h4);
        chk("t5_noto", {timeout, 2'b0, count}, 128'h2);
        repeat (12) do_idle();

        // 6: simultaneous commands, reset during check
        do_clr();
        do_push(4'hA); do_push(4'hB);
        step(0, 0, 0, 1, 1, 4'hC);
        chk("t6_pp", count, 128'h2);
        step(1, 0, 0, 1, 0, 4'hD);
        do_push(4'h9); do_push(4'h8); do_push(4'h7); do_push(4'h6);
        check = 1;
        #2 rstn = 0;
        #1 check = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1;
        repeat (3) do_idle();

        // Random password round trips, exact or perturbed
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(2, 34);
            pw.delete();
            for (int i = 0; i < n; i++) pw.push_back(DW'($urandom_range(0, 15)));
            foreach (pw[i]) do_push(pw[i]);
            do_store();
            r = $urandom_range(0, 3);
            if (r == 1 && pw.size() > 0) pw[$urandom_range(0, pw.size()-1)] ^= 4'h1;
            if (r == 2) void'(pw.pop_back());
            foreach (pw[i]) do_push(pw[i]);
            if (r == 3) begin do_push(4'h0); do_pop(); end
            do_check();
        end

        // Random command mix with idle bursts
        for (int t = 0; t < 600; t++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       do_clr();
            else if (r < 6)  do_store();
            else if (r < 10) do_check();
            else if (r < 28) do_pop();
            else if (r < 62) do_push(DW'($urandom_range(0, 15)));
            else if (r < 65) step(0, 0, 0, 1, 1, DW'($urandom_range(0, 15)));
            else if (r < 92) do_idle();
            else begin
                n = $urandom_range(5, 14);
                repeat (n) do_idle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
